// File: rtl/kbd_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_uart_pkg : shared TX states and 8N1 frame constants            |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package kbd_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 208;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    localparam logic [3:0] IDLE_OH  = 4'b0001;
    localparam logic [3:0] START_OH = 4'b0010;
    localparam logic [3:0] DATA_OH  = 4'b0100;
    localparam logic [3:0] STOP_OH  = 4'b1000;

    typedef enum logic [3:0] {
        IDLE  = IDLE_OH,
        START = START_OH,
        DATA  = DATA_OH,
        STOP  = STOP_OH
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/kbd_uart_tx_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : power-of-two FIFO, head visible combinationally        |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/kbd_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_uart_tx : buffers keyboard characters, sends them as 8N1 UART  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module kbd_uart_tx
    import kbd_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    input  logic                          cts,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] STOP_LAST = 16'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

    tx_state_t   state, next_state;
    logic [7:0]  shift, next_shift;
    logic [15:0] baud, next_baud;
    logic [2:0]  idx, next_idx;
    logic        next_tx;
    logic        pop;
    logic        ready_en;
    logic        full;
    logic        empty;
    logic [7:0]  head;

    // ready_en keeps ready low while reset is held, even though the FIFO is empty.
    assign ready = ready_en && !full;
    assign busy  = (state != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (valid && ready),
        .wr_data (data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            baud     <= '0;
            idx      <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= next_state;
            tx       <= next_tx;
            shift    <= next_shift;
            baud     <= next_baud;
            idx      <= next_idx;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_tx    = tx;
        next_shift = shift;
        next_baud  = baud;
        next_idx   = idx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                next_tx = 1'b1;
                if (!empty && cts) begin
                    pop        = 1'b1;
                    next_shift = head;
                    next_tx    = 1'b0;
                    next_baud  = '0;
                    next_state = START;
                end
            end
            START: begin
                if (baud == BIT_LAST) begin
                    next_baud  = '0;
                    next_tx    = shift[0];
                    next_idx   = '0;
                    next_state = DATA;
                end else begin
                    next_baud = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BIT_LAST) begin
                    next_baud  = '0;
                    next_shift = shift >> 1;
                    if (idx == LAST_IDX) begin
                        next_tx    = 1'b1;
                        next_state = STOP;
                    end else begin
                        next_tx  = shift[1];
                        next_idx = idx + 1'b1;
                    end
                end else begin
                    next_baud = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud == STOP_LAST) begin
                    next_baud  = '0;
                    next_state = IDLE;
                end else begin
                    next_baud = baud + 1'b1;
                end
            end
            default: begin
                next_tx    = 1'b1;
                next_baud  = '0;
                next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
